// File: rtl/led_pkg.sv
// Shared types for the LED sequencer: pattern modes, FSM states, bounce direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ADD    = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_TOGGLE = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/led_step_timer.sv
// Step timer: counts clock cycles while enabled and flags the last cycle of each step.
module led_step_timer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 en,
    input  logic                 clr,
    input  logic [CNT_WIDTH-1:0] step,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;
    logic [CNT_WIDTH-1:0] eff_step;

    // A step of zero would never tick, so it behaves as one cycle per step.
    assign eff_step = (step == '0) ? CNT_WIDTH'(1) : step;
    assign tick     = en && (count_reg == (eff_step - CNT_WIDTH'(1)));

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = tick ? '0 : (count_reg + CNT_WIDTH'(1));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: config register behind a valid/ready port, IDLE/RUN control
// and a four-mode pattern datapath advanced by the step timer.
module led_sequencer
    import led_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CNT_WIDTH    = 32,
    parameter int DEFAULT_STEP = 10,
    parameter int DEFAULT_INC  = 10
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [1:0]           CMD_MODE,
    input  logic [CNT_WIDTH-1:0] CMD_STEP,
    input  logic [WIDTH-1:0]     CMD_INC,
    input  logic                 START,
    input  logic                 STOP,
    output logic [WIDTH-1:0]     LED,
    output logic                 BUSY,
    output logic                 TICK
);

    state_e               state_reg, state_next;
    mode_e                mode_reg;
    logic [CNT_WIDTH-1:0] step_reg;
    logic [WIDTH-1:0]     inc_reg;
    logic [WIDTH-1:0]     led_reg, led_next;
    dir_e                 dir_reg, dir_next;
    logic [WIDTH-1:0]     led_rot;
    logic [WIDTH-1:0]     bounce_shift;
    logic                 cmd_accept;
    logic                 timer_en;
    logic                 timer_clr;
    logic                 step_tick;
    logic                 led_update;

    assign cmd_accept = CMD_VALID && (state_reg == ST_IDLE);
    assign timer_en   = (state_reg == ST_RUN);
    // A coincident STOP wins over the tick, so the held LED value is not advanced.
    assign led_update = step_tick && !STOP;

    assign CMD_READY = (state_reg == ST_IDLE);
    assign BUSY      = (state_reg == ST_RUN);
    assign TICK      = step_tick;
    assign LED       = led_reg;

    led_step_timer #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_timer (
        .CLK  (CLK),
        .RST_N(RST_N),
        .en   (timer_en),
        .clr  (timer_clr),
        .step (step_reg),
        .tick (step_tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign led_rot[gi] = led_reg[(gi + WIDTH - 1) % WIDTH];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        timer_clr  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                timer_clr = 1'b1;
                if (START) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (STOP) begin
                    state_next = ST_IDLE;
                    timer_clr  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        led_next     = led_reg;
        dir_next     = dir_reg;
        bounce_shift = '0;
        if (led_update) begin
            case (mode_reg)
                MODE_ADD: led_next = led_reg + inc_reg;
                MODE_ROTATE: led_next = (led_reg == '0) ? WIDTH'(1) : led_rot;
                MODE_BOUNCE: begin
                    if (!$onehot(led_reg)) begin
                        led_next = WIDTH'(1);
                        dir_next = DIR_LEFT;
                    // At the top bit the only way is down, whatever dir says.
                    end else if (led_reg[WIDTH-1] || (dir_reg == DIR_RIGHT && !led_reg[0])) begin
                        bounce_shift = led_reg >> 1;
                        led_next     = bounce_shift;
                        dir_next     = bounce_shift[0] ? DIR_LEFT : DIR_RIGHT;
                    end else begin
                        bounce_shift = led_reg << 1;
                        led_next     = bounce_shift;
                        dir_next     = bounce_shift[WIDTH-1] ? DIR_RIGHT : DIR_LEFT;
                    end
                end
                MODE_TOGGLE: led_next = led_reg ^ inc_reg;
                default: led_next = led_reg;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_IDLE;
            mode_reg  <= MODE_ADD;
            step_reg  <= CNT_WIDTH'(DEFAULT_STEP);
            inc_reg   <= WIDTH'(DEFAULT_INC);
            led_reg   <= '0;
            dir_reg   <= DIR_LEFT;
        end else begin
            state_reg <= state_next;
            led_reg   <= led_next;
            dir_reg   <= dir_next;
            if (cmd_accept) begin
                mode_reg <= mode_e'(CMD_MODE);
                step_reg <= CMD_STEP;
                inc_reg  <= CMD_INC;
            end
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: expected LED/TICK/BUSY values are computed by hand.
module tb_led_sequencer;

    logic        CLK;
    logic        RST_N;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_MODE;
    logic [31:0] CMD_STEP;
    logic [7:0]  CMD_INC;
    logic        START;
    logic        STOP;
    logic [7:0]  LED;
    logic        BUSY;
    logic        TICK;

    int checks;
    int failures;

    led_sequencer dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_MODE (CMD_MODE),
        .CMD_STEP (CMD_STEP),
        .CMD_INC  (CMD_INC),
        .START    (START),
        .STOP     (STOP),
        .LED      (LED),
        .BUSY     (BUSY),
        .TICK     (TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #3;
        RST_N = 1'b1;
        cycle();
    endtask

    task automatic send_cmd(input logic [1:0] mode, input logic [31:0] step, input logic [7:0] inc);
        CMD_VALID = 1'b1;
        CMD_MODE  = mode;
        CMD_STEP  = step;
        CMD_INC   = inc;
        check("cmd_ready_idle", 32'(CMD_READY), 32'd1);
        cycle();
        CMD_VALID = 1'b0;
        $display("cmd mode=%0d step=%0d inc=0x%0h", mode, step, inc);
    endtask

    task automatic start_run();
        START = 1'b1;
        cycle();
        START = 1'b0;
        check("busy_after_start", 32'(BUSY), 32'd1);
        $display("start led=0x%0h", LED);
    endtask

    task automatic stop_run();
        STOP = 1'b1;
        cycle();
        STOP = 1'b0;
        check("busy_after_stop", 32'(BUSY), 32'd0);
        check("tick_after_stop", 32'(TICK), 32'd0);
        $display("stop led=0x%0h", LED);
    endtask

    logic [7:0] bounce_seq [16];
    logic [7:0] exp_led;
    logic [7:0] held;

    initial begin
        checks    = 0;
        failures  = 0;
        RST_N     = 1'b0;
        CMD_VALID = 1'b0;
        CMD_MODE  = 2'd0;
        CMD_STEP  = 32'd0;
        CMD_INC   = 8'd0;
        START     = 1'b0;
        STOP      = 1'b0;
        bounce_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        // Reset state
        #12;
        check("rst_led", 32'(LED), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_ready", 32'(CMD_READY), 32'd1);
        check("rst_tick", 32'(TICK), 32'd0);
        STOP = 1'b1;
        do_reset();
        STOP = 1'b0;
        check("stop_in_idle_busy", 32'(BUSY), 32'd0);
        $display("reset done");

        // Default ADD: step 10, inc 10, wrap 250 -> 4
        start_run();
        check("add_tick_k0", 32'(TICK), 32'd0);
        for (int k = 1; k <= 260; k++) begin
            cycle();
            exp_led = 8'((10 * (k / 10)) % 256);
            check("add_led", 32'(LED), 32'(exp_led));
            check("add_tick", 32'(TICK), 32'((k % 10) == 9));
        end
        check("add_wrap", 32'(LED), 32'd4);
        $display("add run led=0x%0h", LED);
        stop_run();
        check("add_hold", 32'(LED), 32'd4);

        // ROTATE step 3, with a rejected command mid-run
        do_reset();
        send_cmd(2'd1, 32'd3, 8'd0);
        start_run();
        for (int k = 1; k <= 30; k++) begin
            if (k == 4) begin
                CMD_VALID = 1'b1;
                CMD_MODE  = 2'd3;
                CMD_STEP  = 32'd1;
                CMD_INC   = 8'h55;
                check("ready_in_run", 32'(CMD_READY), 32'd0);
            end
            if (k == 7) CMD_VALID = 1'b0;
            cycle();
            if (k / 3 == 0) exp_led = 8'h00;
            else exp_led = 8'(1 << (((k / 3) - 1) % 8));
            check("rot_led", 32'(LED), 32'(exp_led));
        end
        $display("rotate run led=0x%0h", LED);
        stop_run();

        // BOUNCE step 1, then STOP coincident with TICK
        do_reset();
        send_cmd(2'd2, 32'd1, 8'd0);
        start_run();
        check("bounce_tick_k0", 32'(TICK), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("bounce_led", 32'(LED), 32'(bounce_seq[k-1]));
            check("bounce_tick", 32'(TICK), 32'd1);
        end
        $display("bounce run led=0x%0h", LED);
        stop_run();
        check("bounce_stop_hold", 32'(LED), 32'h02);

        // TOGGLE with step 0, inc 0xFF
        do_reset();
        send_cmd(2'd3, 32'd0, 8'hFF);
        start_run();
        for (int k = 1; k <= 6; k++) begin
            cycle();
            check("toggle_led", 32'(LED), (k % 2 == 1) ? 32'hFF : 32'h00);
            check("toggle_tick", 32'(TICK), 32'd1);
        end
        $display("toggle run led=0x%0h", LED);
        stop_run();

        // START together with a command: new step 2, inc 5
        do_reset();
        CMD_VALID = 1'b1;
        CMD_MODE  = 2'd0;
        CMD_STEP  = 32'd2;
        CMD_INC   = 8'd5;
        START     = 1'b1;
        cycle();
        CMD_VALID = 1'b0;
        START     = 1'b0;
        check("combo_busy", 32'(BUSY), 32'd1);
        cycle();
        check("combo_led_k1", 32'(LED), 32'd0);
        check("combo_tick_k1", 32'(TICK), 32'd1);
        cycle();
        check("combo_led_k2", 32'(LED), 32'd5);
        cycle();
        check("combo_tick_k3", 32'(TICK), 32'd1);
        $display("start+cmd run led=0x%0h", LED);
        // STOP lands on a tick: no update to 10
        held = LED;
        stop_run();
        check("stop_tick_hold", 32'(LED), 32'(held));
        cycle();
        check("stop_tick_hold2", 32'(LED), 32'd5);
        // Re-START continues from the held value with count cleared
        start_run();
        cycle();
        check("restart_k1", 32'(LED), 32'd5);
        cycle();
        check("restart_k2", 32'(LED), 32'd10);

        // Asynchronous reset between edges, mid-run
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_led", 32'(LED), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        check("arst_ready", 32'(CMD_READY), 32'd1);
        #2;
        RST_N = 1'b1;
        cycle();
        $display("async reset done");
        start_run();
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check("post_rst_led", 32'(LED), (k == 10) ? 32'd10 : 32'd0);
        end
        stop_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
